sample_packer: RTL and testbench

- Downstream consumer of the registered a/b/c stage outputs.
- Each enabled cycle it captures one 4-bit sample {a, b, c[1:0]}.
- It packs SAMPLES_PER_WORD samples into one word and buffers words in a small synchronous FIFO.
- Words leave on a valid/ready interface; words lost to back-pressure are counted.

---
 rtl/sample_packer_pkg.sv | 14 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/sample_packer.sv | 127 ++++++++++++
 tb/tb_sample_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sample_packer_pkg.sv
// Shared types for the sample packer: the sample width, the sample type and
// the packing state encoding.
package sample_packer_pkg;

  localparam int SAMPLE_W = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    PK_EMPTY,
    PK_FILLING
  } pack_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with simultaneous push/pop support.
// A push while full is accepted only when a pop happens in the same cycle.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head output reads zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic [CW-1:0]    count_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full_q;
  logic             empty_q;
  logic             pop_ok;
  logic             push_ok;

  assign o_count = wr_ptr - rd_ptr;
  assign pop_ok  = i_pop && !empty_q;
  assign push_ok = i_push && (!full_q || pop_ok);

  // Occupancy after this cycle's accepted push/pop, used for the flag registers
  always_comb begin
    count_n = o_count;
    case ({push_ok, pop_ok})
      2'b10:   count_n = o_count + CW'(1);
      2'b01:   count_n = o_count - CW'(1);
      default: count_n = o_count;
    endcase
  end

  // Pointer and flag registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + CW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + CW'(1);
      full_q  <= (count_n == CW'(DEPTH));
      empty_q <= (count_n == '0);
    end
  end

  // Storage array; contents need no reset because empty gates the head
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_head  = empty_q ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/sample_packer.sv
// Packs 4-bit {a, b, c} samples LSB-first into words, queues them in a
// small FIFO and hands them out on a valid/ready interface. Words that
// arrive while the FIFO is full and not draining are counted as drops.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int SAMPLES_PER_WORD = 4,
  parameter int FIFO_DEPTH       = 4,
  parameter int CNT_W            = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_en,
  input  logic                                 i_a,
  input  logic                                 i_b,
  input  logic [1:0]                           i_c,
  input  logic                                 i_flush,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] o_data,
  output logic                                 o_full,
  output logic                                 o_empty,
  output logic [CNT_W-1:0]                     o_drop_cnt
);

  localparam int DATA_W = SAMPLE_W * SAMPLES_PER_WORD;
  localparam int SLOT_W = $clog2(SAMPLES_PER_WORD);
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SAMPLES_PER_WORD - 1);

  pack_state_t       state_q;
  pack_state_t       state_n;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_n;
  logic [DATA_W-1:0] pack_q;
  logic [DATA_W-1:0] pack_n;
  logic [DATA_W-1:0] with_nib;
  logic [DATA_W-1:0] word;
  logic              push;
  logic              pop;
  logic              drop;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  sample_t           nibble;

  assign nibble = {i_a, i_b, i_c};

  // Pack register with the current sample merged into its slot when enabled
  always_comb begin
    with_nib = pack_q;
    if (i_en) begin
      for (int k = 0; k < SAMPLES_PER_WORD; k++) begin
        if (slot_q == SLOT_W'(k)) with_nib[k*SAMPLE_W +: SAMPLE_W] = nibble;
      end
    end
  end

  // Packing FSM: a completed word or a flush pushes and returns to EMPTY
  always_comb begin
    state_n = state_q;
    slot_n  = slot_q;
    pack_n  = pack_q;
    push    = 1'b0;
    word    = with_nib;
    if (i_en && slot_q == LAST_SLOT) begin
      push    = 1'b1;
      state_n = PK_EMPTY;
      slot_n  = '0;
      pack_n  = '0;
    end else if (i_flush && (state_q == PK_FILLING || i_en)) begin
      push    = 1'b1;
      state_n = PK_EMPTY;
      slot_n  = '0;
      pack_n  = '0;
    end else if (i_en) begin
      state_n = PK_FILLING;
      slot_n  = slot_q + SLOT_W'(1);
      pack_n  = with_nib;
    end
  end

  // Packing state, slot counter and pack register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= PK_EMPTY;
      slot_q  <= '0;
      pack_q  <= '0;
    end else begin
      state_q <= state_n;
      slot_q  <= slot_n;
      pack_q  <= pack_n;
    end
  end

  assign pop  = o_valid && i_ready;
  assign drop = push && (fifo_count == FCW'(FIFO_DEPTH)) && !pop;

  // Saturating count of words lost to a full FIFO
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_drop_cnt <= '0;
    end else if (drop && o_drop_cnt != {CNT_W{1'b1}}) begin
      o_drop_cnt <= o_drop_cnt + CNT_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (word),
    .i_pop   (pop),
    .o_head  (o_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_valid = !fifo_empty;
  assign o_full  = fifo_full;
  assign o_empty = fifo_empty;

endmodule

// File: tb/tb_sample_packer.sv
// Directed testbench for sample_packer. Expected words go into a scoreboard
// queue as stimulus is issued; a monitor compares every accepted word.
module tb_sample_packer;

  logic        i_clk;
  logic        i_rst;
  logic        i_en;
  logic        i_a;
  logic        i_b;
  logic [1:0]  i_c;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data;
  logic        o_full;
  logic        o_empty;
  logic [7:0]  o_drop_cnt;

  logic [15:0] sb [$];
  int          n_checks;
  int          n_fail;

  sample_packer #(
    .SAMPLES_PER_WORD (4),
    .FIFO_DEPTH       (4),
    .CNT_W            (8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_c        (i_c),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_drop_cnt (o_drop_cnt)
  );

  // Free-running clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus; inputs change 1ns after the rising edge
  task automatic applyStimulus(input logic en, input logic [3:0] nib, input logic flush);
    i_en    = en;
    i_a     = nib[3];
    i_b     = nib[2];
    i_c     = nib[1:0];
    i_flush = flush;
    @(posedge i_clk);
    #1;
    i_en    = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic sendWord(input logic [15:0] w);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, w[k*4 +: 4], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'h0, 1'b0);
  endtask

  task automatic drain(input string name);
    int budget;
    i_ready = 1'b1;
    budget  = 0;
    while ((!o_empty || sb.size() != 0) && budget < 40) begin
      idle(1);
      budget++;
    end
    checkOutput({name, "_empty"}, {31'd0, o_empty}, 32'd1);
    checkOutput({name, "_sb_left"}, sb.size(), 32'd0);
  endtask

  // Monitor: each accepted word is compared against the scoreboard head
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst && o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checkOutput("mon_unexpected_word", {16'd0, o_data}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("mon_word", {16'd0, o_data}, {16'd0, sb.pop_front()});
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b0;
    i_en     = 1'b0;
    i_a      = 1'b0;
    i_b      = 1'b0;
    i_c      = 2'b00;
    i_flush  = 1'b0;
    i_ready  = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_empty", {31'd0, o_empty}, 32'd1);
    checkOutput("rst_full",  {31'd0, o_full},  32'd0);
    checkOutput("rst_drop",  {24'd0, o_drop_cnt}, 32'd0);
    checkOutput("rst_data",  {16'd0, o_data},  32'd0);
    i_rst = 1'b1;

    // Basic packing, LSB-first, one cycle of latency
    i_ready = 1'b1;
    sb.push_back(16'hA321);
    applyStimulus(1'b1, 4'h1, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b0);
    checkOutput("basic_not_yet", {31'd0, o_valid}, 32'd0);
    applyStimulus(1'b1, 4'hA, 1'b0);
    checkOutput("basic_valid", {31'd0, o_valid}, 32'd1);
    checkOutput("basic_data", {16'd0, o_data}, 32'h0000_A321);
    idle(1);
    checkOutput("basic_one_cycle", {31'd0, o_valid}, 32'd0);

    // Flush of a partial word, then flush in EMPTY is a no-op
    sb.push_back(16'h0065);
    applyStimulus(1'b1, 4'h5, 1'b0);
    applyStimulus(1'b1, 4'h6, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("flush_valid", {31'd0, o_valid}, 32'd1);
    checkOutput("flush_data", {16'd0, o_data}, 32'h0000_0065);
    idle(1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    idle(1);
    checkOutput("flush_noop_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("flush_noop_empty", {31'd0, o_empty}, 32'd1);

    // Flush in EMPTY together with a sample gives a slot-0-only word
    sb.push_back(16'h0009);
    applyStimulus(1'b1, 4'h9, 1'b1);
    checkOutput("flush_en_data", {16'd0, o_data}, 32'h0000_0009);
    idle(1);

    // Overflow: six words into a four-deep FIFO with no consumer
    i_ready = 1'b0;
    sb.push_back(16'h4321);
    sb.push_back(16'h8765);
    sb.push_back(16'hCBA9);
    sb.push_back(16'h0FED);
    sendWord(16'h4321);
    sendWord(16'h8765);
    sendWord(16'hCBA9);
    checkOutput("ovf_not_full", {31'd0, o_full}, 32'd0);
    sendWord(16'h0FED);
    checkOutput("ovf_full", {31'd0, o_full}, 32'd1);
    sendWord(16'h5A5A);
    sendWord(16'hA5A5);
    checkOutput("ovf_drop", {24'd0, o_drop_cnt}, 32'd2);
    checkOutput("ovf_head", {16'd0, o_data}, 32'h0000_4321);
    drain("ovf_drain");

    // Full FIFO with a pop on the cycle the fifth word completes
    i_ready = 1'b0;
    sb.push_back(16'h1357);
    sb.push_back(16'h2468);
    sb.push_back(16'h9BDF);
    sb.push_back(16'hACE0);
    sb.push_back(16'h7777);
    sendWord(16'h1357);
    sendWord(16'h2468);
    sendWord(16'h9BDF);
    sendWord(16'hACE0);
    applyStimulus(1'b1, 4'h7, 1'b0);
    applyStimulus(1'b1, 4'h7, 1'b0);
    applyStimulus(1'b1, 4'h7, 1'b0);
    i_ready = 1'b1;
    applyStimulus(1'b1, 4'h7, 1'b0);
    i_ready = 1'b0;
    checkOutput("pp_full", {31'd0, o_full}, 32'd1);
    checkOutput("pp_drop", {24'd0, o_drop_cnt}, 32'd2);
    checkOutput("pp_head", {16'd0, o_data}, 32'h0000_2468);
    drain("pp_drain");

    // Reset with a partial word and queued words discards everything
    i_ready = 1'b0;
    sendWord(16'h1111);
    sendWord(16'h2222);
    applyStimulus(1'b1, 4'hF, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b0);
    checkOutput("pre_rst_valid", {31'd0, o_valid}, 32'd1);
    i_rst = 1'b0;
    idle(1);
    i_rst = 1'b1;
    checkOutput("mid_rst_empty", {31'd0, o_empty}, 32'd1);
    checkOutput("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("mid_rst_drop",  {24'd0, o_drop_cnt}, 32'd0);
    checkOutput("mid_rst_data",  {16'd0, o_data}, 32'd0);
    i_ready = 1'b1;
    sb.push_back(16'h4321);
    applyStimulus(1'b1, 4'h1, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b0);
    applyStimulus(1'b1, 4'h4, 1'b0);
    checkOutput("post_rst_data", {16'd0, o_data}, 32'h0000_4321);
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
